// File: rtl/ca_pkg.sv
// ca_pkg: shared state encoding, LFSR constants and default geometry for the
// elementary cellular-automaton row engine.
package ca_pkg;

  localparam int          CA_WIDTH_DEF  = 640;
  localparam int          CA_HEIGHT_DEF = 480;

  // Fibonacci taps 32,22,2,1 expressed as a bit mask over lfsr[31:0].
  localparam logic [31:0] CA_LFSR_TAPS  = 32'h8020_0003;
  localparam logic [31:0] CA_LFSR_SEED  = 32'h0000_0001;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEED  = 3'd1,
    ST_WRITE = 3'd2,
    ST_GEN   = 3'd3,
    ST_DONE  = 3'd4
  } ca_state_e;

  // Look up the rule bit selected by the neighbourhood {left, centre, right}.
  function automatic logic ca_rule_bit(input logic [7:0] rule, input logic l,
                                       input logic c, input logic r);
    return rule[{l, c, r}];
  endfunction

  // Feedback bit of the Fibonacci LFSR: XOR of all tapped positions.
  function automatic logic ca_lfsr_fb(input logic [31:0] q);
    return ^(q & CA_LFSR_TAPS);
  endfunction

endpackage

// File: rtl/ca_lfsr32.sv
// ca_lfsr32: free-running 32-bit Fibonacci LFSR used as the random row seed
// source. Only instantiated when CA_LFSR_SEED_EN is defined.
module ca_lfsr32
  import ca_pkg::*;
(
  input  logic iCLK,
  input  logic iRST_N,
  output logic oBit
);

  logic [31:0] lfsr_q;
  logic [31:0] lfsr_d;

  // Next state: shift towards the MSB and feed the tap parity into bit 0.
  always_comb begin
    lfsr_d = {lfsr_q[30:0], ca_lfsr_fb(lfsr_q)};
  end

  // State register; advances every cycle outside reset.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      lfsr_q <= CA_LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign oBit = lfsr_q[0];

endmodule

// File: rtl/ca_row_engine.sv
// ca_row_engine: generates HEIGHT generations of an elementary cellular
// automaton, WIDTH cells wide, and streams every cell to a framebuffer at
// address row*WIDTH+col, one cell per cycle.
// Optional feature: define CA_LFSR_SEED_EN to build the LFSR random seed
// (iSeedMode=1 then fills row 0 from the LFSR over WIDTH cycles). Without it
// iSeedMode is ignored and every run starts from a single centre cell.
module ca_row_engine
  import ca_pkg::*;
#(
  parameter int WIDTH  = CA_WIDTH_DEF,
  parameter int HEIGHT = CA_HEIGHT_DEF,
  parameter int ADDR_W = 19
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iStart,
  input  logic              iHold,
  input  logic [7:0]        iRule,
  input  logic              iWrap,
  input  logic              iSeedMode,
  output logic              oWe,
  output logic [ADDR_W-1:0] oAddr,
  output logic              oData,
  output logic              oBusy,
  output logic              oDone,
  output logic [2:0]        oState
);

  localparam int               COL_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int               ROW_W    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
  localparam logic [WIDTH-1:0] SINGLE_SEED = {{(WIDTH-1){1'b0}}, 1'b1} << (WIDTH / 2);

  ca_state_e        state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic [7:0]       rule_q, rule_d;
  logic             wrap_q, wrap_d;
  logic             rand_seed_q, rand_seed_d;

  logic             lfsr_bit_s;
  logic             seed_sel_s;
  logic [WIDTH+1:0] ext_s;
  logic [WIDTH-1:0] next_row_s;

`ifdef CA_LFSR_SEED_EN
  ca_lfsr32 u_lfsr (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .oBit   (lfsr_bit_s)
  );
  assign seed_sel_s = iSeedMode;
`else
  logic seed_mode_unused_s;
  assign seed_mode_unused_s = iSeedMode;
  assign lfsr_bit_s         = 1'b0;
  assign seed_sel_s         = 1'b0;
`endif

  // Row extended by one boundary cell on each side: ext_s[0] is the left
  // neighbour of cell 0, ext_s[WIDTH+1] the right neighbour of the last cell.
  assign ext_s = {(wrap_q ? cur_q[0] : 1'b0), cur_q, (wrap_q ? cur_q[WIDTH-1] : 1'b0)};

  // Next generation, every cell evaluated in parallel from its neighbourhood.
  always_comb begin
    next_row_s = '0;
    for (int c = 0; c < WIDTH; c++) begin
      next_row_s[c] = ca_rule_bit(rule_q, ext_s[c], ext_s[c+1], ext_s[c+2]);
    end
  end

  // FSM next-state and datapath update; iHold freezes everything.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    cur_d       = cur_q;
    rule_d      = rule_q;
    wrap_d      = wrap_q;
    rand_seed_d = rand_seed_q;
    if (iHold) begin
      state_d = state_q;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (iStart) begin
            state_d     = ST_SEED;
            rule_d      = iRule;
            wrap_d      = iWrap;
            rand_seed_d = seed_sel_s;
            row_d       = '0;
            col_d       = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SEED: begin
          if (rand_seed_q) begin
            cur_d[col_q] = lfsr_bit_s;
            if (col_q == COL_LAST) begin
              col_d   = '0;
              state_d = ST_WRITE;
            end else begin
              col_d = col_q + COL_ONE;
            end
          end else begin
            cur_d   = SINGLE_SEED;
            col_d   = '0;
            state_d = ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_GEN;
            end
          end else begin
            col_d = col_q + COL_ONE;
          end
        end
        ST_GEN: begin
          cur_d   = next_row_s;
          row_d   = row_q + ROW_ONE;
          col_d   = '0;
          state_d = ST_WRITE;
        end
        ST_DONE: begin
          row_d   = '0;
          col_d   = '0;
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state_q     <= ST_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      cur_q       <= '0;
      rule_q      <= 8'h00;
      wrap_q      <= 1'b0;
      rand_seed_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      cur_q       <= cur_d;
      rule_q      <= rule_d;
      wrap_q      <= wrap_d;
      rand_seed_q <= rand_seed_d;
    end
  end

  // Moore outputs decoded from registers; a hold suppresses the write strobe.
  assign oWe    = (state_q == ST_WRITE) && !iHold;
  assign oAddr  = ADDR_W'(row_q) * ADDR_W'(WIDTH) + ADDR_W'(col_q);
  assign oData  = cur_q[col_q];
  assign oBusy  = (state_q != ST_IDLE);
  assign oDone  = (state_q == ST_DONE);
  assign oState = state_q;

endmodule

// File: tb/tb_ca_row_engine.sv
// tb_ca_row_engine: self-checking bench with two engines (8x4 and 4x3),
// checked against a behavioural cellular-automaton model.
`timescale 1ns/1ps
module tb_ca_row_engine;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_start, a_hold, a_wrap, a_seed;
  logic [7:0]    a_rule;
  logic          a_we, a_data, a_busy, a_done;
  logic [AW-1:0] a_addr;
  logic [2:0]    a_state;
  logic          b_start, b_hold, b_wrap, b_seed;
  logic [7:0]    b_rule;
  logic          b_we, b_data, b_busy, b_done;
  logic [AW-1:0] b_addr;
  logic [2:0]    b_state;

  int   edge_cnt = 0;
  int   errors = 0;
  int   checks = 0;
  logic fb [0:31];

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  ca_row_engine #(.WIDTH(8), .HEIGHT(4), .ADDR_W(AW)) dut_a (
    .iCLK(clk), .iRST_N(rst_n), .iStart(a_start), .iHold(a_hold), .iRule(a_rule),
    .iWrap(a_wrap), .iSeedMode(a_seed), .oWe(a_we), .oAddr(a_addr), .oData(a_data),
    .oBusy(a_busy), .oDone(a_done), .oState(a_state)
  );

  ca_row_engine #(.WIDTH(4), .HEIGHT(3), .ADDR_W(AW)) dut_b (
    .iCLK(clk), .iRST_N(rst_n), .iStart(b_start), .iHold(b_hold), .iRule(b_rule),
    .iWrap(b_wrap), .iSeedMode(b_seed), .oWe(b_we), .oAddr(b_addr), .oData(b_data),
    .oBusy(b_busy), .oDone(b_done), .oState(b_state)
  );

  // Reference: row r of a run from a single centre cell, col 0 in bit w-1.
  function automatic logic [7:0] model_row(input logic [7:0] rule, input logic wrap,
                                           input int w, input int r);
    int cells [8];
    int nxt [8];
    logic [7:0] res;
    for (int c = 0; c < 8; c++) cells[c] = (c == w / 2) ? 1 : 0;
    for (int g = 0; g < r; g++) begin
      for (int c = 0; c < w; c++) begin
        int l, rr, idx;
        if (c > 0) l = cells[c-1]; else l = wrap ? cells[w-1] : 0;
        if (c < w - 1) rr = cells[c+1]; else rr = wrap ? cells[0] : 0;
        idx = 4 * l + 2 * cells[c] + rr;
        nxt[c] = rule[idx] ? 1 : 0;
      end
      for (int c = 0; c < w; c++) cells[c] = nxt[c];
    end
    res = 8'h00;
    for (int c = 0; c < w; c++) res[w-1-c] = (cells[c] != 0);
    return res;
  endfunction

  task automatic drive(input bit sel, input logic start, input logic hold,
                       input logic [7:0] rule, input logic wrap, input logic seed);
    if (sel) begin
      b_start = start; b_hold = hold; b_rule = rule; b_wrap = wrap; b_seed = seed;
    end else begin
      a_start = start; a_hold = hold; a_rule = rule; a_wrap = wrap; a_seed = seed;
    end
  endtask

  // Start one run on the selected engine and capture every write into fb.
  // Timings are edges counted from the edge that samples the start (edge 0).
  task automatic run(input bit sel, input logic [7:0] rule, input logic wrap,
                     input logic seed, input int hold_addr, input int hold_len,
                     output int first_we, output int first_addr, output int done_edge,
                     output int done_cnt, output int writes, output int hold_we,
                     output int hits);
    int e0, hold_left;
    bit arm, armed_once;
    logic start_v, hold_v, wrap_v, seed_v, we, data, done, hold_now;
    logic [7:0] rule_v;
    logic [AW-1:0] addr;
    for (int i = 0; i < 32; i++) fb[i] = 1'bx;
    first_we = -1; first_addr = -1; done_edge = -1; done_cnt = 0; writes = 0;
    hold_we = 0; hits = 0; hold_left = 0; arm = 1'b0; armed_once = 1'b0;
    start_v = 1'b1; hold_v = 1'b0; rule_v = rule; wrap_v = wrap; seed_v = seed;
    @(negedge clk);
    drive(sel, start_v, hold_v, rule_v, wrap_v, seed_v);
    e0 = edge_cnt + 1;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) begin
        start_v = 1'b0; rule_v = ~rule; wrap_v = ~wrap; seed_v = ~seed;
      end else if (k == 12) begin
        start_v = 1'b1;
      end else if (k == 13) begin
        start_v = 1'b0;
      end
      if (arm) begin
        hold_v = 1'b1; hold_left = hold_len; arm = 1'b0;
      end else if (hold_left > 0) begin
        hold_left--;
        if (hold_left == 0) hold_v = 1'b0;
      end
      drive(sel, start_v, hold_v, rule_v, wrap_v, seed_v);
      @(negedge clk);
      we = sel ? b_we : a_we;
      data = sel ? b_data : a_data;
      done = sel ? b_done : a_done;
      addr = sel ? b_addr : a_addr;
      hold_now = sel ? b_hold : a_hold;
      if (hold_now && we) hold_we++;
      if (we) begin
        if (addr < 32) fb[addr] = data;
        writes++;
        if (first_we < 0) begin
          first_we = edge_cnt - e0;
          first_addr = int'(addr);
        end
        if (int'(addr) == hold_addr) hits++;
        if (hold_len > 0 && !armed_once && int'(addr) == hold_addr - 1) begin
          arm = 1'b1; armed_once = 1'b1;
        end
      end
      if (done) begin
        done_cnt++;
        if (done_edge < 0) done_edge = edge_cnt - e0;
      end
      if (done_edge >= 0 && !done) break;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (a_state !== 3'd0) begin errors++; $display("FAIL reset_state_a: got %0d expected 0", a_state); end
    checks++; if (a_we !== 1'b0 || a_busy !== 1'b0 || a_done !== 1'b0) begin errors++;
      $display("FAIL reset_outs_a: got we=%b busy=%b done=%b expected 0 0 0", a_we, a_busy, a_done); end
    checks++; if (a_addr !== 8'd0) begin errors++; $display("FAIL reset_addr_a: got %0d expected 0", a_addr); end
    checks++; if (b_state !== 3'd0 || b_busy !== 1'b0 || b_we !== 1'b0) begin errors++;
      $display("FAIL reset_b: got state=%0d busy=%b we=%b expected 0 0 0", b_state, b_busy, b_we); end
    rst_n = 1'b1;
  endtask

  task automatic test_rule90();
    int fw, fa, de, dc, wr, hw, hi;
    logic [7:0] exp_rows [4];
    exp_rows = '{8'b00001000, 8'b00010100, 8'b00100010, 8'b01010101};
    run(1'b0, 8'd90, 1'b0, 1'b0, -1, 0, fw, fa, de, dc, wr, hw, hi);
    checks++; if (fw !== 1) begin errors++; $display("FAIL first_we_edge: got %0d expected 1", fw); end
    checks++; if (fa !== 0) begin errors++; $display("FAIL first_addr: got %0d expected 0", fa); end
    checks++; if (wr !== 32) begin errors++; $display("FAIL write_count: got %0d expected 32", wr); end
    checks++; if (dc !== 1) begin errors++; $display("FAIL done_pulse_len: got %0d expected 1", dc); end
    checks++; if (de !== 36) begin errors++; $display("FAIL done_edge: got %0d expected 36", de); end
    for (int r = 0; r < 4; r++) begin
      logic [7:0] got;
      got = 8'h00;
      for (int c = 0; c < 8; c++) got[7-c] = fb[r*8+c];
      checks++; if (got !== exp_rows[r]) begin errors++;
        $display("FAIL rule90_row%0d: got %b expected %b", r, got, exp_rows[r]); end
    end
  endtask

  task automatic test_wrap_boundary();
    int fw, fa, de, dc, wr, hw, hi;
    logic [3:0] got;
    logic [3:0] exp_r2 [2];
    exp_r2 = '{4'b1000, 4'b0000};
    for (int m = 0; m < 2; m++) begin
      run(1'b1, 8'd90, m[0], 1'b0, -1, 0, fw, fa, de, dc, wr, hw, hi);
      got = 4'h0;
      for (int c = 0; c < 4; c++) got[3-c] = fb[8+c];
      checks++; if (got !== exp_r2[m]) begin errors++;
        $display("FAIL wrap%0d_row2: got %b expected %b", m, got, exp_r2[m]); end
      checks++; if (de !== 15 || wr !== 12) begin errors++;
        $display("FAIL wrap%0d_timing: got done_edge=%0d writes=%0d expected 15 12", m, de, wr); end
    end
  endtask

  task automatic test_hold();
    int fw, fa, de, dc, wr, hw, hi;
    logic wrap;
    wrap = 1'($urandom_range(0, 1));
    run(1'b0, 8'd30, wrap, 1'b0, 11, 5, fw, fa, de, dc, wr, hw, hi);
    checks++; if (hw !== 0) begin errors++; $display("FAIL hold_no_write: got %0d writes while held expected 0", hw); end
    checks++; if (hi !== 1) begin errors++; $display("FAIL hold_col3_once: got %0d writes expected 1", hi); end
    checks++; if (de !== 41) begin errors++; $display("FAIL hold_done_edge: got %0d expected 41", de); end
    checks++; if (wr !== 32) begin errors++; $display("FAIL hold_writes: got %0d expected 32", wr); end
    for (int r = 0; r < 4; r++) begin
      logic [7:0] got;
      got = 8'h00;
      for (int c = 0; c < 8; c++) got[7-c] = fb[r*8+c];
      checks++; if (got !== model_row(8'd30, wrap, 8, r)) begin errors++;
        $display("FAIL hold_row%0d: got %b expected %b", r, got, model_row(8'd30, wrap, 8, r)); end
    end
  endtask

  task automatic test_reset_mid_run();
    int fw, fa, de, dc, wr, hw, hi;
    bit found;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 8'd90, 1'b0, 1'b0);
    @(negedge clk);
    a_start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (a_we && a_addr >= 8'd16) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL midrun_reach_row2: got no row-2 write expected one"); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (a_state !== 3'd0 || a_we !== 1'b0 || a_busy !== 1'b0 || a_done !== 1'b0) begin errors++;
      $display("FAIL midrun_reset: got state=%0d we=%b busy=%b done=%b expected 0 0 0 0",
               a_state, a_we, a_busy, a_done); end
    rst_n = 1'b1;
    run(1'b0, 8'd150, 1'b1, 1'b0, -1, 0, fw, fa, de, dc, wr, hw, hi);
    checks++; if (fa !== 0 || fw !== 1) begin errors++;
      $display("FAIL restart_first: got addr=%0d edge=%0d expected 0 1", fa, fw); end
    for (int r = 0; r < 4; r++) begin
      logic [7:0] got;
      got = 8'h00;
      for (int c = 0; c < 8; c++) got[7-c] = fb[r*8+c];
      checks++; if (got !== model_row(8'd150, 1'b1, 8, r)) begin errors++;
        $display("FAIL restart_row%0d: got %b expected %b", r, got, model_row(8'd150, 1'b1, 8, r)); end
    end
  endtask

  task automatic test_random_runs();
    int fw, fa, de, dc, wr, hw, hi, w, h;
    logic [7:0] rule;
    logic wrap, seed;
    bit sel;
    for (int n = 0; n < 8; n++) begin
      sel = n[0];
      w = sel ? 4 : 8;
      h = sel ? 3 : 4;
      rule = 8'($urandom_range(0, 255));
      wrap = 1'($urandom_range(0, 1));
`ifdef CA_LFSR_SEED_EN
      seed = 1'b0;
`else
      seed = 1'($urandom_range(0, 1));
`endif
      run(sel, rule, wrap, seed, -1, 0, fw, fa, de, dc, wr, hw, hi);
      checks++; if (de !== 1 + h * w + h - 1 || dc !== 1 || wr !== h * w) begin errors++;
        $display("FAIL rand%0d_timing: got done_edge=%0d done_cnt=%0d writes=%0d expected %0d 1 %0d",
                 n, de, dc, wr, 1 + h * w + h - 1, h * w); end
      for (int r = 0; r < h; r++) begin
        logic [7:0] got;
        got = 8'h00;
        for (int c = 0; c < w; c++) got[w-1-c] = fb[r*w+c];
        checks++; if (got !== model_row(rule, wrap, w, r)) begin errors++;
          $display("FAIL rand%0d_row%0d: got %b expected %b (rule %0d wrap %b)",
                   n, r, got, model_row(rule, wrap, w, r), rule, wrap); end
      end
    end
  endtask

  task automatic test_seed_mode();
    int fw, fa, de, dc, wr, hw, hi;
    logic [7:0] row0 [2];
    for (int n = 0; n < 2; n++) begin
      repeat (3 + 5 * n) @(negedge clk);
      run(1'b0, 8'd90, 1'b0, 1'b1, -1, 0, fw, fa, de, dc, wr, hw, hi);
      row0[n] = 8'h00;
      for (int c = 0; c < 8; c++) row0[n][7-c] = fb[c];
`ifdef CA_LFSR_SEED_EN
      checks++; if (de !== 43 || wr !== 32) begin errors++;
        $display("FAIL lfsr%0d_timing: got done_edge=%0d writes=%0d expected 43 32", n, de, wr); end
`else
      checks++; if (row0[n] !== 8'b00001000 || de !== 36) begin errors++;
        $display("FAIL seedmode%0d_ignored: got row0=%b done_edge=%0d expected 00001000 36", n, row0[n], de); end
`endif
    end
`ifdef CA_LFSR_SEED_EN
    checks++; if (row0[0] === row0[1]) begin errors++;
      $display("FAIL lfsr_rows_differ: got %b and %b expected different", row0[0], row0[1]); end
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    test_reset();
    test_rule90();
    test_wrap_boundary();
    test_hold();
    test_reset_mid_run();
    test_random_runs();
    test_seed_mode();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ca_row_engine.md
CA_ROW_ENGINE -- requirements
Module: ca_row_engine

Interface
REQ-001 SHALL provide parameter WIDTH, default 640: cells per row and pixels per framebuffer line.
REQ-002 SHALL provide parameter HEIGHT, default 480: number of generations (rows) written per run.
REQ-003 SHALL provide parameter ADDR_W, default 19: framebuffer address width.
REQ-004 SHALL have port iCLK  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port iRST_N  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port iStart  in  1  level-sampled start request; accepted only in IDLE.
REQ-007 SHALL have port iHold  in  1  freeze the run (state, counters, rows) while high.
REQ-008 SHALL have port iRule  in  8  elementary CA rule number, latched on start.
REQ-009 SHALL have port iWrap  in  1  boundary mode, latched on start: 1 = toroidal, 0 = zero-padded.
REQ-010 SHALL have port iSeedMode  in  1  seed select, latched on start: 0 = single centre cell, 1 = LFSR random.
REQ-011 SHALL have port oWe  out  1  framebuffer write enable.
REQ-012 SHALL have port oAddr  out  ADDR_W  framebuffer address = row*WIDTH + col.
REQ-013 SHALL have port oData  out  1  cell value to write.
REQ-014 SHALL have port oBusy  out  1  high in every state except IDLE.
REQ-015 SHALL have port oDone  out  1  one-cycle pulse at end of run.
REQ-016 SHALL have port oState  out  3  current FSM state, for display on the 7-segment outputs.

Function
REQ-017 SHALL implement FSM states IDLE, SEED, WRITE, GEN, DONE.
REQ-018 Transition IDLE->SEED SHALL occur on the first edge with iStart=1; the same edge SHALL latch iRule, iWrap and iSeedMode.
REQ-019 SEED with single-cell seed SHALL take 1 cycle, load cur[WIDTH/2]=1 and clear all other cells, then go to WRITE.
REQ-020 WRITE SHALL output one cell per cycle, col 0..WIDTH-1, with oWe=1, oData=cur[col] and oAddr=row*WIDTH+col, all Moore outputs decoded from registers.
REQ-021 After col WIDTH-1, WRITE SHALL go to GEN if row<HEIGHT-1, else to DONE.
REQ-022 GEN SHALL take 1 cycle, compute every cell in parallel as next[c]=rule[{L,C,R}], load it into cur, increment row, reset col to 0 and return to WRITE.
REQ-023 In GEN, L and R at c=0 and c=WIDTH-1 SHALL be 0 when wrap=0 and the opposite end cell when wrap=1.
REQ-024 DONE SHALL last 1 cycle with oDone=1, then go to IDLE; iStart in DONE SHALL be ignored.
REQ-025 iStart while oBusy=1 SHALL be ignored; iRule, iWrap and iSeedMode changes mid-run SHALL have no effect.
REQ-026 iHold=1 SHALL hold all registers except the LFSR and force oWe=0; on release the run SHALL resume at the held col.
REQ-027 A single-seed run SHALL last 1 + HEIGHT*WIDTH + (HEIGHT-1) cycles from SEED entry to DONE entry, excluding hold cycles.

Reset
REQ-028 iRST_N=0 SHALL, at the next edge and at any point in a run, force IDLE, row=0, col=0, cur=0, oWe=0, oBusy=0, oDone=0 and LFSR=32'h0000_0001.

Configuration
REQ-029 With CA_LFSR_SEED_EN defined, a free-running 32-bit Fibonacci LFSR (taps 32,22,2,1) SHALL advance every cycle outside reset.
REQ-030 With CA_LFSR_SEED_EN defined and iSeedMode=1, SEED SHALL last WIDTH cycles, shifting the LFSR bit 0 into cur[col] for col 0..WIDTH-1; run length then grows by WIDTH-1 cycles.
REQ-031 Without CA_LFSR_SEED_EN, the LFSR SHALL not be built, iSeedMode SHALL be ignored and every run SHALL use the single-cell seed.

Structure
REQ-032 Shared package ca_pkg SHALL hold the state encoding, the LFSR tap constant, the LFSR reset seed and default WIDTH/HEIGHT.
REQ-033 The LFSR SHALL be a sub-module ca_lfsr32 (ports iCLK, iRST_N, oBit), instantiated only under CA_LFSR_SEED_EN.

Verification
REQ-034 WIDTH=8, HEIGHT=4, rule 90, wrap=0, single seed -> rows written 00001000, 00010100, 00100010, 01010101 (col0 leftmost).
REQ-035 WIDTH=4, HEIGHT=3, rule 90, single seed -> row2 = 1000 when wrap=0 and 0000 when wrap=1.
REQ-036 WIDTH=8, HEIGHT=4, start sampled at edge 0 -> oWe first high after edge 1; exactly 32 writes; oDone high for one cycle after edge 36.
REQ-037 iRST_N=0 during row 2 -> next cycle IDLE, oWe=0, oBusy=0; a new start then rewrites from address 0.
REQ-038 iHold high for 5 cycles at col 3 -> no writes during the hold; col 3 written once after release; oDone delayed by exactly 5 cycles.
REQ-039 With CA_LFSR_SEED_EN, two runs started at different cycle offsets -> row0 contents differ; with the macro undefined and iSeedMode=1 -> single-cell row0.
